// File: rtl/writeback_queue.sv
// writeback_queue
//   Writeback stage in front of the 8x16 register file. Results from the ALU
//   and the load path are buffered in a small in-order FIFO and retired one per
//   cycle through the register file's single write port. A per-register
//   pending mask lets decode stall on RAW hazards.
//
// Ports
//   clk                       rising-edge clock
//   rst_n                     synchronous, active-low reset
//   alu_valid/alu_ready       ALU result handshake; alu_rd, alu_data payload
//   mem_valid/mem_ready       load result handshake; mem_rd, mem_data payload
//   rf_we, rf_rd, rf_data     register file write port (registered)
//   pending_mask              bit r set while a queued or in-flight write targets r
//   count                     current FIFO occupancy
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [2:0]    alu_rd,
  input  logic [15:0]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [2:0]    mem_rd,
  input  logic [15:0]   mem_data,
  output logic          rf_we,
  output logic [2:0]    rf_rd,
  output logic [15:0]   rf_data,
  output logic [7:0]    pending_mask,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    rd_mem   [DEPTH];
  logic [15:0]   data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [2:0]    rf_rd_q, rf_rd_d;
  logic [15:0]   rf_data_q, rf_data_d;

  logic [CW-1:0] free;
  logic          mem_acc;
  logic          alu_acc;
  logic          pop;
  logic [PW-1:0] alu_slot;
  logic [7:0]    pend;

  // Readiness is derived from the registered occupancy only, so a pop in the
  // same cycle never opens a slot combinationally. The load path has priority
  // for the last free slot.
  assign free      = CW'(DEPTH) - count_q;
  assign mem_ready = (free != '0);
  assign alu_ready = (free >= CW'(2)) | ((free != '0) & ~mem_valid);
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;
  assign pop       = (count_q != '0);
  // When both are accepted, mem takes the tail slot and alu the next one.
  assign alu_slot  = tail_q + PW'(mem_acc);

  always_comb begin
    head_d    = head_q + PW'(pop);
    tail_d    = tail_q + PW'(mem_acc) + PW'(alu_acc);
    count_d   = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    rf_we_d   = pop;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (pop) begin
      rf_rd_d   = rd_mem[head_q];
      rf_data_d = data_mem[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: entries are only observed through count_q.
  // Accepts never exceed the free slots, so the head being popped is never
  // overwritten in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      rd_mem[tail_q]   <= mem_rd;
      data_mem[tail_q] <= mem_data;
    end
    if (alu_acc) begin
      rd_mem[alu_slot]   <= alu_rd;
      data_mem[alu_slot] <= alu_data;
    end
  end

  // Occupied slots are the count_q entries starting at the head, plus the
  // write currently presented to the register file.
  always_comb begin
    pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pend[rd_mem[head_q + PW'(k)]] = 1'b1;
      end
    end
    if (rf_we_q) begin
      pend[rf_rd_q] = 1'b1;
    end
  end

  assign pending_mask = pend;
  assign count        = count_q;
  assign rf_we        = rf_we_q;
  assign rf_rd        = rf_rd_q;
  assign rf_data      = rf_data_q;

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback stage directly upstream of the 8x16 register file.
- Collects results from two producers, the ALU and the memory/load path, and serialises them into the register file's single write port (we, rd, data_in).
- Buffers results in a small in-order FIFO and retires at most one per cycle.
- Exports a per-register pending mask so the decode stage can stall on RAW hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, 3, width of count = log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid=1.
- alu_rd  input  3  destination register of ALU result.
- alu_data  input  16  ALU result value.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  load result accepted this cycle when mem_valid=1.
- mem_rd  input  3  destination register of load result.
- mem_data  input  16  load result value.
- rf_we  output  1  register file write enable (register-file we).
- rf_rd  output  3  register file write address (register-file rd).
- rf_data  output  16  register file write data (register-file data_in).
- pending_mask  output  8  bit r = 1 while any queued or in-flight write targets register r.
- count  output  CW  current FIFO occupancy.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears the FIFO (count=0, pointers=0) and sets rf_we=0, rf_rd=0, rf_data=0. pending_mask then reads 0.
- Reset mid-operation drops all queued entries; no register file write occurs for them.
- Ready generation: free = DEPTH - count, using the registered count only; there is no combinational path from a same-cycle pop.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) | ((free >= 1) & ~mem_valid).
- Enqueue ordering: a handshake is valid & ready. When both sources handshake in the same cycle, mem is written first (tail) and alu second (tail+1). Tail advances by the number accepted (0, 1 or 2).
- Dequeue:
  - Each edge with count > 0 pops the head and loads rf_we=1, rf_rd=head.rd, rf_data=head.data.
  - Each edge with count = 0 loads rf_we=0; rf_rd and rf_data hold their previous values.
  - count_next = count + accepted - popped. Simultaneous push and pop is legal at any occupancy, including full.
- Latency: a result accepted in cycle N with the FIFO empty is written into the FIFO at edge N, popped at edge N+1, and shows rf_we=1 throughout cycle N+2. Sustained throughput is 1 write/cycle.
- Ordering: strict FIFO order. Two writes to the same rd retire in acceptance order, so the later value wins in the register file.
- Register r0 gets no special treatment; it is writable.
- Pointers: 2-bit (log2 DEPTH) wrap-around modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- pending_mask: combinational OR of one-hot(rd) over all valid FIFO entries, plus one-hot(rf_rd) when rf_we=1.
- Full: mem_ready=0 and alu_ready=0. An offered result must be held by its producer until ready; values presented while not ready are ignored.
- Free = 1 with both sources valid: mem accepted, alu stalled.
- The register file is assumed always able to accept; there is no back-pressure on rf_*.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then rst_n=1, no valids.
  - Required: rf_we=0, count=0, pending_mask=8'h00, alu_ready=1, mem_ready=1.
- Single ALU write:
  - Stimulus: alu_valid=1, alu_rd=3, alu_data=16'hBEEF for one cycle N.
  - Required: pending_mask=8'h08 from cycle N+1; rf_we=1, rf_rd=3, rf_data=16'hBEEF in cycle N+2; pending_mask=8'h00 in cycle N+3.
- Dual accept ordering:
  - Stimulus: same cycle mem (rd=5, 16'h1111) and alu (rd=5, 16'h2222) with FIFO empty.
  - Required: both ready=1; rf writes 16'h1111 then 16'h2222 to r5 on consecutive cycles; pending bit 5 set until the second write completes.
- Fill to full:
  - Stimulus: alu_valid held with rd=0..6 and data=16'h0100+i while mem_valid=1 streams rd=7.
  - Required: count never exceeds 4; ready drops at full; mem wins when free=1; every accepted value is written exactly once, in order, with no loss.
- Full with simultaneous pop:
  - Stimulus: count=4, mem_valid=1.
  - Required: mem_ready=0 that cycle (registered count); next cycle count=3 and mem_ready=1.
- Reset mid-stream:
  - Stimulus: rst_n=0 for one edge with count=3 and rf_we=1.
  - Required: next cycle rf_we=0, count=0, pending_mask=0, and none of the 3 queued writes appear.
